// File: rtl/tinycpu_pkg.sv
// Shared tinycpu bus definitions: strobe encoding, default widths and loader states.
package tinycpu_pkg;

  localparam int unsigned TC_AW = 8;
  localparam int unsigned TC_DW = 8;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/sram_loader.sv
// Host program loader: streams bytes into consecutive addresses from a burst base.
module sram_loader
  import tinycpu_pkg::*;
#(
  parameter int unsigned AW = TC_AW,
  parameter int unsigned DW = TC_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_busy,
  output logic          wr_en_c,
  output logic [AW-1:0] wr_addr_c,
  output logic [DW-1:0] wr_data_c
);

  // One extra bit so a zero length can hold the full 2**AW count.
  localparam int unsigned RW = AW + 1;

  ld_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          ld_ready_q, ld_ready_d;
  logic          ld_done_q, ld_done_d;
  logic          ld_busy_q, ld_busy_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    wr_en_c   = 1'b0;
    wr_addr_c = ptr_q;
    wr_data_c = ld_data;
    case (state_q)
      L_IDLE: begin
        if (ld_start) begin
          ptr_d   = ld_base;
          rem_d   = (ld_len == '0) ? {1'b1, {AW{1'b0}}} : RW'(ld_len);
          state_d = L_LOAD;
        end
      end
      L_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          wr_en_c = 1'b1;
          ptr_d   = ptr_q + AW'(1);
          rem_d   = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = L_DONE;
        end
      end
      L_DONE:  state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
    // Outputs registered from the next state so they line up with state_q.
    ld_ready_d = (state_d == L_LOAD);
    ld_busy_d  = (state_d == L_LOAD);
    ld_done_d  = (state_d == L_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= L_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      ld_busy_q  <= ld_busy_d;
    end
  end

  assign ld_ready = ld_ready_q;
  assign ld_done  = ld_done_q;
  assign ld_busy  = ld_busy_q;

endmodule

// File: rtl/sram_target.sv
// Clocked SRAM responder for the tinycpu async-SRAM bus with loader port and debug counters.
module sram_target
  import tinycpu_pkg::*;
#(
  parameter int unsigned AW    = TC_AW,
  parameter int unsigned DW    = TC_DW,
  parameter int unsigned DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          cen,
  input  logic          oen,
  input  logic          wen,
  inout  wire  [DW-1:0] dq,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_busy,
  output logic          bus_err,
  output logic          wr_collide,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt
);

  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [DW-1:0] mem [DEPTH];

  logic          ld_we_c;
  logic [AW-1:0] ld_waddr_c;
  logic [DW-1:0] ld_wdata_c;

  logic rd_c, bus_we_c, viol_c, collide_c;

  logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            wr_collide_q, wr_collide_d;

  sram_loader #(
    .AW (AW),
    .DW (DW)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_busy   (ld_busy),
    .wr_en_c   (ld_we_c),
    .wr_addr_c (ld_waddr_c),
    .wr_data_c (ld_wdata_c)
  );

  // Bus decode; a low wen always suppresses the read path.
  always_comb begin
    rd_c      = (cen == ACTIVE) && (oen == ACTIVE) && (wen == INACTIVE);
    bus_we_c  = (cen == ACTIVE) && (wen == ACTIVE);
    viol_c    = (cen == ACTIVE) && (oen == ACTIVE) && (wen == ACTIVE);
    collide_c = bus_we_c && ld_we_c && (addr == ld_waddr_c);
  end

  assign dq = rd_c ? mem[addr] : {DW{1'bz}};

  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    bus_err_d    = bus_err_q | viol_c;
    wr_collide_d = wr_collide_q | collide_c;
    if (rd_c && (rd_cnt_q != CNT_MAX))     rd_cnt_d = rd_cnt_q + CNTW'(1);
    if (bus_we_c && (wr_cnt_q != CNT_MAX)) wr_cnt_d = wr_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      bus_err_q    <= 1'b0;
      wr_collide_q <= 1'b0;
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      bus_err_q    <= bus_err_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  // Storage survives reset; on an address clash the loader write wins.
  always_ff @(posedge clk) begin
    if (bus_we_c && !collide_c) mem[addr] <= dq;
    if (ld_we_c)                mem[ld_waddr_c] <= ld_wdata_c;
  end

  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign bus_err    = bus_err_q;
  assign wr_collide = wr_collide_q;

endmodule
